// File: rtl/hs32_fetch.sv
// hs32_fetch: HS32 instruction fetch unit with prefetch FIFO and flush redirect
// Ports: clk, reset (async active-low); flush/newpc redirect from exec;
// reqd/rdyd/instd/pcd decode instruction interface; reqm/rdym/addr/dtrm memory read port.
module hs32_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] newpc,
  input  logic        reqd,
  output logic        rdyd,
  output logic [31:0] instd,
  output logic [31:0] pcd,
  output logic        reqm,
  input  logic        rdym,
  output logic [31:0] addr,
  input  logic [31:0] dtrm
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state, state_n;
  logic [31:0] fpc, fpc_n, tgt, ftgt;
  logic [31:0] pcs [DEPTH];
  logic [31:0] insts [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] occ, occ_n;
  logic push, pop, load;
  assign rdyd  = occ != '0;
  assign instd = insts[rp];
  assign pcd   = pcs[rp];
  assign reqm  = state != IDLE;
  assign addr  = fpc;
  // occ_n includes the in-flight request, so staying in REQ only when it is
  // below DEPTH guarantees room for whatever completes next
  always_comb begin
    ftgt    = {newpc[31:2], 2'b00};
    pop     = reqd && rdyd && !flush;
    push    = state == REQ && rdym && !flush;
    occ_n   = flush ? '0 : occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    load    = flush ? (state == IDLE || rdym) : (state == DISCARD && rdym);
    fpc_n   = load ? (flush ? ftgt : tgt) : push ? fpc + 32'd4 : fpc;
    state_n = load ? REQ
            : (state == REQ && flush) ? DISCARD
            : state == DISCARD ? DISCARD
            : occ_n < FULL ? REQ : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      fpc   <= RESET_PC;
      tgt   <= RESET_PC;
      occ   <= '0;
      rp    <= '0;
      wp    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcs[i]   <= '0;
        insts[i] <= '0;
      end
    end else begin
      state <= state_n;
      fpc   <= fpc_n;
      occ   <= occ_n;
      if (flush) begin
        tgt <= ftgt;
        rp  <= '0;
        wp  <= '0;
      end else begin
        if (push) begin
          pcs[wp]   <= fpc;
          insts[wp] <= dtrm;
          wp        <= wp + AW'(1);
        end
        if (pop) rp <= rp + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_hs32_fetch.sv
// tb_hs32_fetch: directed vector bench for hs32_fetch
module tb_hs32_fetch;
  localparam logic [31:0] K = 32'hCAFE_BABE;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0, reqd = 1'b0, rdym = 1'b0;
  logic [31:0] newpc = '0;
  logic rdyd, reqm;
  logic [31:0] instd, pcd, addr, dtrm;
  int checks = 0, errors = 0;
  hs32_fetch #(.DEPTH(2), .RESET_PC(32'h1000)) dut (
    .clk(clk), .reset(reset), .flush(flush), .newpc(newpc), .reqd(reqd),
    .rdyd(rdyd), .instd(instd), .pcd(pcd), .reqm(reqm), .rdym(rdym),
    .addr(addr), .dtrm(dtrm)
  );
  always #5 clk = ~clk;
  assign dtrm = addr ^ K;
  typedef struct {
    logic        reqd, rdym, flush;
    logic [31:0] newpc;
    logic        rdyd, reqm;
    logic [31:0] pcd, addr;
  } vec_t;
  vec_t v [29];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h1000};
    v[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1000,      32'h1004};
    v[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h1000,      32'h1008};
    v[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h1000,      32'h1008};
    v[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1004,      32'h1008};
    v[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1008,      32'h100C};
    v[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100C,      32'h1010};
    v[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1010,      32'h1014};
    v[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1014,      32'h1018};
    v[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h1018};
    v[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h1018};
    v[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h1018};
    v[12] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1018,      32'h101C};
    v[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h101C};
    v[14] = '{1'b0, 1'b0, 1'b1, 32'h2002,      1'b0, 1'b1, 32'h0,         32'h101C};
    v[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h101C};
    v[16] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h2000};
    v[17] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2000,      32'h2004};
    v[18] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2004,      32'h2008};
    v[19] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0,         32'hFFFF_FFFC};
    v[20] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0};
    v[21] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4};
    v[22] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h8};
    v[23] = '{1'b1, 1'b0, 1'b1, 32'h3003,      1'b0, 1'b1, 32'h0,         32'h3000};
    v[24] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h3000,      32'h3004};
    v[25] = '{1'b0, 1'b0, 1'b1, 32'h4000,      1'b0, 1'b1, 32'h0,         32'h3004};
    v[26] = '{1'b0, 1'b0, 1'b1, 32'h5005,      1'b0, 1'b1, 32'h0,         32'h3004};
    v[27] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h5004};
    v[28] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h5004,      32'h5008};
    for (int c = 0; c < 4; c++) begin
      reqd  = 1'($urandom);
      rdym  = 1'($urandom);
      flush = 1'($urandom);
      newpc = $urandom;
      step();
      chk($sformatf("rst%0d rdyd", c), {31'b0, rdyd}, 32'h0);
      chk($sformatf("rst%0d reqm", c), {31'b0, reqm}, 32'h0);
      chk($sformatf("rst%0d instd", c), instd, 32'h0);
      chk($sformatf("rst%0d pcd", c), pcd, 32'h0);
      chk($sformatf("rst%0d addr", c), addr, 32'h1000);
    end
    reqd = 1'b0; rdym = 1'b0; flush = 1'b0; newpc = '0;
    reset = 1'b1;
    for (int i = 0; i < 29; i++) begin
      reqd  = v[i].reqd;
      rdym  = v[i].rdym;
      flush = v[i].flush;
      newpc = v[i].newpc;
      step();
      chk($sformatf("v%0d rdyd", i), {31'b0, rdyd}, {31'b0, v[i].rdyd});
      chk($sformatf("v%0d reqm", i), {31'b0, reqm}, {31'b0, v[i].reqm});
      chk($sformatf("v%0d addr", i), addr, v[i].addr);
      if (v[i].rdyd) begin
        chk($sformatf("v%0d pcd", i), pcd, v[i].pcd);
        chk($sformatf("v%0d instd", i), instd, v[i].pcd ^ K);
      end
    end
    reqd = 1'b0; rdym = 1'b0; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst reqm", {31'b0, reqm}, 32'h0);
    chk("midrst rdyd", {31'b0, rdyd}, 32'h0);
    chk("midrst addr", addr, 32'h1000);
    chk("midrst pcd", pcd, 32'h0);
    chk("midrst instd", instd, 32'h0);
    step();
    reset = 1'b1;
    step();
    chk("post reqm", {31'b0, reqm}, 32'h1);
    chk("post addr", addr, 32'h1000);
    chk("post rdyd", {31'b0, rdyd}, 32'h0);
    rdym = 1'b1;
    step();
    chk("post2 rdyd", {31'b0, rdyd}, 32'h1);
    chk("post2 pcd", pcd, 32'h1000);
    chk("post2 instd", instd, 32'h1000 ^ K);
    chk("post2 addr", addr, 32'h1004);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
